// File: rtl/dec_secded_pipe_pkg.sv
// rtl/dec_secded_pipe_pkg.sv - shared types and helpers for the SEC-DED decoder (package enc_dec_pkg)
package enc_dec_pkg;

  typedef enum logic [1:0] {
    CLEAN         = 2'd0,
    CORRECTED     = 2'd1,
    UNCORRECTABLE = 2'd2
  } status_e;

  // Widest supported configuration (M=6): 64-bit codeword, 57 data bits.
  localparam int MAX_CW_W   = 64;
  localparam int MAX_DATA_W = 57;

  function automatic int cw_width(input int m);
    return 1 << m;
  endfunction

  function automatic int data_width(input int m);
    return (1 << m) - m - 1;
  endfunction

  function automatic logic is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Data bits occupy the non-power-of-two positions above bit 0, LSB lowest.
  function automatic logic [MAX_DATA_W-1:0] extract_data(input logic [MAX_CW_W-1:0] cw,
                                                         input int m);
    logic [MAX_DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < MAX_CW_W; i++) begin
      if ((i < (1 << m)) && !is_pow2(i)) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/dec_secded_pipe_if.sv
// rtl/dec_secded_pipe_if.sv - codeword-in / decoded-result-out handshake bundle
interface dec_secded_pipe_if #(
  parameter int M = 3
);
  import enc_dec_pkg::*;

  localparam int CW_W   = cw_width(M);
  localparam int DATA_W = data_width(M);

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   codeword_with_errors;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] mul_result;
  status_e           status;
  logic [M:0]        err_pos;

  modport master (
    output in_valid, codeword_with_errors, out_ready,
    input  in_ready, out_valid, mul_result, status, err_pos
  );

  modport slave (
    input  in_valid, codeword_with_errors, out_ready,
    output in_ready, out_valid, mul_result, status, err_pos
  );

endinterface

// File: rtl/dec_syndrome_calc.sv
// rtl/dec_syndrome_calc.sv - combinational Hamming syndrome and overall parity of a codeword
module dec_syndrome_calc #(
  parameter int M = 3
) (
  input  logic [(1<<M)-1:0] codeword_i,
  output logic [M-1:0]      syndrome_o,
  output logic              parity_o
);

  // Syndrome is the XOR of the indices of every set Hamming-position bit.
  always_comb begin
    syndrome_o = '0;
    for (int i = 1; i < (1 << M); i++) begin
      if (codeword_i[i]) begin
        syndrome_o = syndrome_o ^ i[M-1:0];
      end
    end
    parity_o = ^codeword_i;
  end

endmodule

// File: rtl/dec_secded_pipe.sv
// rtl/dec_secded_pipe.sv - two-stage SEC-DED decoder; optional error counters under DEC_ERR_CNT_EN
module dec_secded_pipe
  import enc_dec_pkg::*;
#(
  parameter int M     = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  dec_secded_pipe_if.slave  bus,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam int CW_W   = cw_width(M);
  localparam int DATA_W = data_width(M);

  logic              adv1, adv2;
  logic [M-1:0]      syn_d;
  logic              par_d;

  logic              s1_valid_q;
  logic [CW_W-1:0]   s1_cw_q;
  logic [M-1:0]      s1_syn_q;
  logic              s1_par_q;

  logic [CW_W-1:0]   fixed_cw;
  logic [DATA_W-1:0] data_d;
  status_e           status_d;
  logic [M:0]        pos_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  status_e           status_q;
  logic [M:0]        pos_q;

  // A stage advances when it is empty or its consumer takes its word this cycle.
  assign adv2         = !out_valid_q || bus.out_ready;
  assign adv1         = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

  dec_syndrome_calc #(.M(M)) u_syndrome (
    .codeword_i (bus.codeword_with_errors),
    .syndrome_o (syn_d),
    .parity_o   (par_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_cw_q  <= bus.codeword_with_errors;
        s1_syn_q <= syn_d;
        s1_par_q <= par_d;
      end
    end
  end

  // Odd overall parity means a single flip at position s (s=0 is the parity bit itself).
  always_comb begin
    fixed_cw = s1_cw_q;
    status_d = CLEAN;
    pos_d    = '0;
    if (s1_par_q) begin
      fixed_cw[s1_syn_q] = ~s1_cw_q[s1_syn_q];
      status_d           = CORRECTED;
      pos_d              = {1'b0, s1_syn_q};
    end else if (s1_syn_q != '0) begin
      status_d = UNCORRECTABLE;
    end
    data_d = DATA_W'(extract_data(MAX_CW_W'(fixed_cw), M));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      status_q    <= CLEAN;
      pos_q       <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= data_d;
        status_q <= status_d;
        pos_q    <= pos_d;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.mul_result = data_q;
  assign bus.status     = status_q;
  assign bus.err_pos    = pos_q;

`ifdef DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_fire;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  assign out_fire = out_valid_q && bus.out_ready;

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clear) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_fire) begin
      if ((status_q == CORRECTED) && (corr_cnt_q != CNT_MAX)) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
      if ((status_q == UNCORRECTABLE) && (uncorr_cnt_q != CNT_MAX)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign corr_cnt         = '0;
  assign uncorr_cnt       = '0;
`endif

endmodule

// File: tb/tb_dec_secded_pipe.sv
// tb/tb_dec_secded_pipe.sv - scoreboard bench for dec_secded_pipe (M=3, CNT_W=16 and CNT_W=2)
`timescale 1ns/1ps
module tb_dec_secded_pipe;
  import enc_dec_pkg::*;

  localparam int M      = 3;
  localparam int CNT_W  = 16;
  localparam int CNT2_W = 2;

  typedef struct {
    logic [3:0] data;
    logic [1:0] st;
    logic [3:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cnt_clear = 1'b0;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
  logic [CNT2_W-1:0] corr_cnt2, uncorr_cnt2;

  always #5 clk = ~clk;

  dec_secded_pipe_if #(.M(M)) dif ();
  dec_secded_pipe_if #(.M(M)) dif2 ();

  assign dif2.in_valid             = dif.in_valid;
  assign dif2.codeword_with_errors = dif.codeword_with_errors;
  assign dif2.out_ready            = dif.out_ready;

  dec_secded_pipe #(.M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(dif.slave),
    .cnt_clear(cnt_clear), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  dec_secded_pipe #(.M(M), .CNT_W(CNT2_W)) dut2 (
    .clk(clk), .rst(rst), .bus(dif2.slave),
    .cnt_clear(cnt_clear), .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   m_corr = 0, m_uncorr = 0, m_corr2 = 0, m_uncorr2 = 0;
  logic stalled = 1'b0;
  exp_t held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] cw;
    logic [2:0] s;
    int k;
    cw = '0;
    k  = 0;
    for (int i = 1; i < 8; i++) begin
      if (i != 1 && i != 2 && i != 4) begin
        cw[i] = d[k];
        k++;
      end
    end
    s = '0;
    for (int i = 1; i < 8; i++) if (cw[i]) s = s ^ i[2:0];
    cw[1] = s[0];
    cw[2] = s[1];
    cw[4] = s[2];
    cw[0] = ^cw[7:1];
    return cw;
  endfunction

  function automatic logic [3:0] data_of(input logic [7:0] cw);
    return {cw[7], cw[6], cw[5], cw[3]};
  endfunction

  function automatic exp_t mk(input logic [3:0] d, input logic [1:0] st, input logic [3:0] pos);
    exp_t e;
    e.data = d;
    e.st   = st;
    e.pos  = pos;
    return e;
  endfunction

  task automatic gen(input int nerr, output logic [7:0] cw, output exp_t e);
    logic [3:0] d;
    int a, b;
    d  = 4'($urandom);
    cw = encode(d);
    e  = mk(d, 2'd0, 4'd0);
    if (nerr == 1) begin
      a = $urandom_range(7, 0);
      cw[a] = ~cw[a];
      e = mk(d, 2'd1, 4'(a));
    end else if (nerr == 2) begin
      a = $urandom_range(7, 0);
      b = (a + int'($urandom_range(7, 1))) % 8;
      cw[a] = ~cw[a];
      cw[b] = ~cw[b];
      e = mk(data_of(cw), 2'd2, 4'd0);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] cw, input exp_t e);
    int waited = 0;
    dif.in_valid = 1'b1;
    dif.codeword_with_errors = cw;
    @(negedge clk);
    while (!dif.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    else sb.push_back(e);
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    dif.out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: counter model, hold-while-stalled, scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("corr_cnt", 64'(corr_cnt), 64'(m_corr));
      check("uncorr_cnt", 64'(uncorr_cnt), 64'(m_uncorr));
      check("corr_cnt2", 64'(corr_cnt2), 64'(m_corr2));
      check("uncorr_cnt2", 64'(uncorr_cnt2), 64'(m_uncorr2));
      if (stalled) begin
        check("hold_valid", 64'(dif.out_valid), 64'd1);
        check("hold_data", 64'(dif.mul_result), 64'(held.data));
        check("hold_status", 64'(dif.status), 64'(held.st));
        check("hold_pos", 64'(dif.err_pos), 64'(held.pos));
      end
      stalled   = dif.out_valid && !dif.out_ready;
      held.data = dif.mul_result;
      held.st   = dif.status;
      held.pos  = dif.err_pos;
      if (dif.out_valid && dif.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("data", 64'(dif.mul_result), 64'(e.data));
          check("status", 64'(dif.status), 64'(e.st));
          check("err_pos", 64'(dif.err_pos), 64'(e.pos));
`ifdef DEC_ERR_CNT_EN
          if (e.st == 2'd1) begin
            m_corr  = (m_corr < 65535) ? m_corr + 1 : m_corr;
            m_corr2 = (m_corr2 < 3) ? m_corr2 + 1 : m_corr2;
          end
          if (e.st == 2'd2) begin
            m_uncorr  = (m_uncorr < 65535) ? m_uncorr + 1 : m_uncorr;
            m_uncorr2 = (m_uncorr2 < 3) ? m_uncorr2 + 1 : m_uncorr2;
          end
`endif
        end
      end
      if (cnt_clear) begin
        m_corr = 0; m_uncorr = 0; m_corr2 = 0; m_uncorr2 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cw;
    exp_t e;
    dif.in_valid = 1'b0;
    dif.codeword_with_errors = '0;
    dif.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(dif.out_valid), 64'd0);
    check("rst_data", 64'(dif.mul_result), 64'd0);
    check("rst_status", 64'(dif.status), 64'd0);
    check("rst_pos", 64'(dif.err_pos), 64'd0);
    check("rst_corr", 64'(corr_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(dif.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors and two-cycle latency
    send(8'hCC, mk(4'b1101, 2'd0, 4'd0));
    @(negedge clk);
    check("lat_cycle1", 64'(dif.out_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(dif.out_valid), 64'd1);
    @(posedge clk);
    #1;
    send(8'hEC, mk(4'b1101, 2'd1, 4'd5));
    send(8'hCD, mk(4'b1101, 2'd1, 4'd0));
    send(8'hAC, mk(data_of(8'hAC), 2'd2, 4'd0));
    drain();

    // 10-word stream with a 3-cycle back-pressure window
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          gen(i % 3, cw, e);
          send(cw, e);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 64'(dif.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 dif.out_ready = 1'b1;
      end
    join
    drain();

    // Random errors with random back-pressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          gen(int'($urandom_range(2, 0)), cw, e);
          send(cw, e);
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(posedge clk);
          #1 dif.out_ready = 1'($urandom);
        end
        dif.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight
    send(8'hEC, mk(4'b1101, 2'd1, 4'd5));
    send(8'hCC, mk(4'b1101, 2'd0, 4'd0));
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(dif.out_valid), 64'd0);
    check("midrst_corr", 64'(corr_cnt), 64'd0);
    check("midrst_uncorr", 64'(uncorr_cnt), 64'd0);
    check("midrst_status", 64'(dif.status), 64'd0);
    sb.delete();
    m_corr = 0; m_uncorr = 0; m_corr2 = 0; m_uncorr2 = 0;
    stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(dif.in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(8'hCC, mk(4'b1101, 2'd0, 4'd0));
    drain();

    // cnt_clear coincident with a CORRECTED handshake
    send(8'hEC, mk(4'b1101, 2'd1, 4'd5));
    @(posedge clk);
    #1 cnt_clear = 1'b1;
    check("clr_coincide_valid", 64'(dif.out_valid), 64'd1);
    @(posedge clk);
    #1 cnt_clear = 1'b0;
    @(negedge clk);
    check("clr_priority", 64'(corr_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Five CORRECTED words: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      gen(1, cw, e);
      send(cw, e);
    end
    drain();
    @(negedge clk);
`ifdef DEC_ERR_CNT_EN
    check("sat_corr_cnt2", 64'(corr_cnt2), 64'd3);
    check("sat_corr_cnt", 64'(corr_cnt), 64'd5);
`else
    check("nocnt_corr_cnt2", 64'(corr_cnt2), 64'd0);
    check("nocnt_corr_cnt", 64'(corr_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_secded_pipe.md
# dec_secded_pipe

Parametrised, pipelined SEC-DED (extended Hamming) decoder, successor to the fixed 8-bit combinational decoder matrix multiplier. Accepts a 2^M-bit codeword per valid/ready transfer, corrects any single-bit error, flags double-bit errors, and returns the data bits with a status code two cycles later. It sits between the channel/error-injection stage and the data sink of the encoder–decoder chain. Optional saturating error counters support link statistics.

## Interface
- M, default 3: number of Hamming parity bits; codeword width CW_W = 2**M, data width DATA_W = 2**M − M − 1 (M=3 gives 8/4). Legal range 3..6.
- CNT_W, default 16: width of each error counter.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  codeword present.
- in_ready  output  1  block accepts on in_valid && in_ready.
- codeword_with_errors  input  CW_W  received codeword.
- out_valid  output  1  result present.
- out_ready  input  1  sink accepts on out_valid && out_ready.
- mul_result  output  DATA_W  decoded (corrected) data.
- status  output  2  0 CLEAN, 1 CORRECTED, 2 UNCORRECTABLE.
- err_pos  output  M+1  corrected bit index (0..CW_W−1); 0 when CLEAN or UNCORRECTABLE.
- cnt_clear  input  1  synchronous clear of both counters.
- corr_cnt  output  CNT_W  count of CORRECTED results delivered.
- uncorr_cnt  output  CNT_W  count of UNCORRECTABLE results delivered.

## Operation
- Bit map: bit 0 = overall parity; bits 1..CW_W−1 = Hamming positions; parity at power-of-two positions; data bits at remaining positions ascending, data LSB at lowest position (M=3: d0..d3 at bits 3,5,6,7).
- Stage 1 (S1): register syndrome s = XOR of indices of set bits in 1..CW_W−1 (M bits), overall parity p = XOR of all CW_W bits, and the raw codeword.
- Stage 2 (S2): classify and register outputs:
  - s=0, p=0: CLEAN, data unchanged.
  - p=1: CORRECTED, flip bit s (s=0 means bit 0 flipped, data unchanged), err_pos=s.
  - s≠0, p=0: UNCORRECTABLE, data passed uncorrected, err_pos=0.
- Counters increment on output handshake with matching status; saturate at 2**CNT_W−1; cnt_clear has priority over a simultaneous increment (result 0).

## Timing
- Latency: 2 cycles from input handshake to out_valid with no back-pressure; throughput 1 word/cycle.
- Stall: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational from out_ready, no bubble).
- out_valid, mul_result, status, err_pos held stable while out_valid && !out_ready.
- Reset (any time, including mid-transfer): s1_valid, out_valid = 0; mul_result, status, err_pos, corr_cnt, uncorr_cnt = 0; in_ready = 1 after reset deasserts; in-flight words discarded.
- Pipeline empty and in_valid=0: outputs hold last values, out_valid=0.

## Configuration
- DEC_ERR_CNT_EN defined: counters and cnt_clear logic present as above.
- Not defined: counter registers removed; corr_cnt and uncorr_cnt tied to 0; cnt_clear ignored. Datapath and timing identical.

## Structure
- Package enc_dec_pkg: status enum (CLEAN, CORRECTED, UNCORRECTABLE), functions for CW_W/DATA_W from M, data-position extraction, is-power-of-two.
- Sub-module dec_syndrome_calc (combinational, parametrised by M): codeword in, syndrome and overall parity out; instanced in S1.

## Test plan
- M=3, codeword 8'hCC, out_ready=1 -> two cycles later mul_result=4'b1101, status CLEAN, err_pos=0.
- 8'hEC (bit 5 flipped) -> 1101, CORRECTED, err_pos=5, corr_cnt 0->1; 8'hCD (bit 0) -> 1101, CORRECTED, err_pos=0.
- 8'hAC (bits 5,6 flipped) -> status UNCORRECTABLE, err_pos=0, uncorr_cnt increments.
- Back-to-back stream of 10 words with out_ready low for 3 cycles mid-stream -> in_ready drops after pipeline fills, no word lost/duplicated, order preserved, outputs stable while stalled.
- Assert rst with two words in flight -> out_valid=0 immediately, counters 0, next word decodes correctly; cnt_clear coincident with CORRECTED handshake -> corr_cnt=0.
- CNT_W=2, five CORRECTED words -> corr_cnt saturates at 3; build without DEC_ERR_CNT_EN -> counts stay 0.
